// File: rtl/sobel_pkg.sv
// Shared types, width helpers and window indexing for the Sobel gradient pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_GY  = 2'd1,
    MODE_GX  = 2'd2,
    MODE_MAX = 2'd3
  } sobel_mode_e;

  localparam int unsigned PIX_W_DEFAULT = 8;
  localparam int unsigned GRAD_W        = PIX_W_DEFAULT + 3;
  localparam int unsigned ABS_W         = PIX_W_DEFAULT + 2;

  function automatic int unsigned grad_w(input int unsigned pix_w);
    return pix_w + 3;
  endfunction

  function automatic int unsigned abs_w(input int unsigned pix_w);
    return pix_w + 2;
  endfunction

  // Row-major index into the 3x3 window, P0 top-left.
  function automatic int unsigned pix_idx(input int unsigned row, input int unsigned col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/sobel_kernel_sum.sv
// Weighted 1-2-1 sum of vector a minus weighted 1-2-1 sum of vector b, combinational.
module sobel_kernel_sum
  import sobel_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic [PIX_W-1:0]        a0_i,
  input  logic [PIX_W-1:0]        a1_i,
  input  logic [PIX_W-1:0]        a2_i,
  input  logic [PIX_W-1:0]        b0_i,
  input  logic [PIX_W-1:0]        b1_i,
  input  logic [PIX_W-1:0]        b2_i,
  output logic signed [PIX_W+2:0] diff_o
);

  localparam int unsigned GradW = grad_w(PIX_W);

  logic [GradW-1:0] sum_a;
  logic [GradW-1:0] sum_b;

  always_comb begin
    sum_a  = GradW'(a0_i) + (GradW'(a1_i) << 1) + GradW'(a2_i);
    sum_b  = GradW'(b0_i) + (GradW'(b1_i) << 1) + GradW'(b2_i);
    diff_o = signed'(sum_a - sum_b);
  end

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Three-stage Sobel gx/gy engine with mode-selected magnitude, saturation, edge flag
// and a saturating edge counter; one global advance stalls every stage together.
module sobel_gradient_pipe
  import sobel_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 20
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [9*PIX_W-1:0] window_i,
  input  logic [1:0]         mode_i,
  input  logic [PIX_W+2:0]   threshold_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PIX_W+1:0]   gx_abs_o,
  output logic [PIX_W+1:0]   gy_abs_o,
  output logic               gx_neg_o,
  output logic               gy_neg_o,
  output logic [PIX_W+2:0]   mag_o,
  output logic [PIX_W-1:0]   pix_out_o,
  output logic               edge_o,
  input  logic               cnt_clear_i,
  output logic [CNT_W-1:0]   edge_count_o
);

  localparam int unsigned GradW = grad_w(PIX_W);
  localparam int unsigned AbsW  = abs_w(PIX_W);

  logic [PIX_W-1:0] pix [9];
  logic             advance;

  logic signed [GradW-1:0] gx_d, gy_d;
  logic signed [GradW-1:0] s1_gx_q, s1_gy_q;
  logic                    s1_valid_q;
  sobel_mode_e             s1_mode_q;
  logic [GradW-1:0]        s1_thr_q;

  logic [AbsW-1:0]  gx_abs_d, gy_abs_d;
  logic [AbsW-1:0]  s2_gx_abs_q, s2_gy_abs_q;
  logic             s2_gx_neg_q, s2_gy_neg_q, s2_valid_q;
  sobel_mode_e      s2_mode_q;
  logic [GradW-1:0] s2_thr_q;

  logic [GradW-1:0] mag_d, mag_q;
  logic [PIX_W-1:0] pix_d, pix_q;
  logic             edge_d, edge_q;
  logic [AbsW-1:0]  gx_abs_q, gy_abs_q;
  logic             gx_neg_q, gy_neg_q, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    for (int k = 0; k < 9; k++) pix[k] = window_i[k*PIX_W +: PIX_W];
  end

  assign advance = !out_valid_q || out_ready_i;

  // Rows give gy (top minus bottom), columns give gx (right minus left).
  sobel_kernel_sum #(.PIX_W(PIX_W)) u_gy (
    .a0_i  (pix[pix_idx(0, 0)]),
    .a1_i  (pix[pix_idx(0, 1)]),
    .a2_i  (pix[pix_idx(0, 2)]),
    .b0_i  (pix[pix_idx(2, 0)]),
    .b1_i  (pix[pix_idx(2, 1)]),
    .b2_i  (pix[pix_idx(2, 2)]),
    .diff_o(gy_d)
  );

  sobel_kernel_sum #(.PIX_W(PIX_W)) u_gx (
    .a0_i  (pix[pix_idx(0, 2)]),
    .a1_i  (pix[pix_idx(1, 2)]),
    .a2_i  (pix[pix_idx(2, 2)]),
    .b0_i  (pix[pix_idx(0, 0)]),
    .b1_i  (pix[pix_idx(1, 0)]),
    .b2_i  (pix[pix_idx(2, 0)]),
    .diff_o(gx_d)
  );

  always_comb begin
    gx_abs_d = s1_gx_q[GradW-1] ? AbsW'(-s1_gx_q) : AbsW'(s1_gx_q);
    gy_abs_d = s1_gy_q[GradW-1] ? AbsW'(-s1_gy_q) : AbsW'(s1_gy_q);

    mag_d = '0;
    unique case (s2_mode_q)
      MODE_SUM: mag_d = GradW'(s2_gx_abs_q) + GradW'(s2_gy_abs_q);
      MODE_GY:  mag_d = GradW'(s2_gy_abs_q);
      MODE_GX:  mag_d = GradW'(s2_gx_abs_q);
      MODE_MAX: mag_d = (s2_gx_abs_q > s2_gy_abs_q) ? GradW'(s2_gx_abs_q) : GradW'(s2_gy_abs_q);
      default:  mag_d = '0;
    endcase
    pix_d  = (|mag_d[GradW-1:PIX_W]) ? '1 : mag_d[PIX_W-1:0];
    edge_d = mag_d >= s2_thr_q;

    // Clear wins over a same-cycle increment.
    cnt_d = cnt_q;
    if (cnt_clear_i) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready_i && edge_q && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_gx_q     <= '0;
      s1_gy_q     <= '0;
      s1_mode_q   <= MODE_SUM;
      s1_thr_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_gx_abs_q <= '0;
      s2_gy_abs_q <= '0;
      s2_gx_neg_q <= 1'b0;
      s2_gy_neg_q <= 1'b0;
      s2_mode_q   <= MODE_SUM;
      s2_thr_q    <= '0;
      out_valid_q <= 1'b0;
      gx_abs_q    <= '0;
      gy_abs_q    <= '0;
      gx_neg_q    <= 1'b0;
      gy_neg_q    <= 1'b0;
      mag_q       <= '0;
      pix_q       <= '0;
      edge_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (advance) begin
        s1_valid_q  <= in_valid_i;
        s1_gx_q     <= gx_d;
        s1_gy_q     <= gy_d;
        s1_mode_q   <= sobel_mode_e'(mode_i);
        s1_thr_q    <= threshold_i;
        s2_valid_q  <= s1_valid_q;
        s2_gx_abs_q <= gx_abs_d;
        s2_gy_abs_q <= gy_abs_d;
        s2_gx_neg_q <= s1_gx_q[GradW-1];
        s2_gy_neg_q <= s1_gy_q[GradW-1];
        s2_mode_q   <= s1_mode_q;
        s2_thr_q    <= s1_thr_q;
        out_valid_q <= s2_valid_q;
        gx_abs_q    <= s2_gx_abs_q;
        gy_abs_q    <= s2_gy_abs_q;
        gx_neg_q    <= s2_gx_neg_q;
        gy_neg_q    <= s2_gy_neg_q;
        mag_q       <= mag_d;
        pix_q       <= pix_d;
        edge_q      <= edge_d;
      end
    end
  end

  assign in_ready_o   = advance;
  assign out_valid_o  = out_valid_q;
  assign gx_abs_o     = gx_abs_q;
  assign gy_abs_o     = gy_abs_q;
  assign gx_neg_o     = gx_neg_q;
  assign gy_neg_o     = gy_neg_q;
  assign mag_o        = mag_q;
  assign pix_out_o    = pix_q;
  assign edge_o       = edge_q;
  assign edge_count_o = cnt_q;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Self-checking bench: arithmetic reference model plus queue scoreboard, directed vectors.
module tb_sobel_gradient_pipe;

  localparam int PW = 8;
  localparam int WW = 9 * PW;
  localparam int TW = PW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, out_ready, cnt_clear;
  logic [WW-1:0] window;
  logic [1:0]    mode;
  logic [TW-1:0] threshold;

  logic          in_ready, out_valid, gx_neg, gy_neg, edg;
  logic [PW+1:0] gx_abs, gy_abs;
  logic [TW-1:0] mag;
  logic [PW-1:0] pix_out;
  logic [19:0]   ec20;

  logic          in_ready3, out_valid3, gx_neg3, gy_neg3, edg3;
  logic [PW+1:0] gx_abs3, gy_abs3;
  logic [TW-1:0] mag3;
  logic [PW-1:0] pix_out3;
  logic [2:0]    ec3;

  sobel_gradient_pipe #(.PIX_W(PW), .CNT_W(20)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .window_i(window), .mode_i(mode), .threshold_i(threshold), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .gx_abs_o(gx_abs), .gy_abs_o(gy_abs), .gx_neg_o(gx_neg),
    .gy_neg_o(gy_neg), .mag_o(mag), .pix_out_o(pix_out), .edge_o(edg),
    .cnt_clear_i(cnt_clear), .edge_count_o(ec20)
  );

  sobel_gradient_pipe #(.PIX_W(PW), .CNT_W(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready3),
    .window_i(window), .mode_i(mode), .threshold_i(threshold), .out_valid_o(out_valid3),
    .out_ready_i(out_ready), .gx_abs_o(gx_abs3), .gy_abs_o(gy_abs3), .gx_neg_o(gx_neg3),
    .gy_neg_o(gy_neg3), .mag_o(mag3), .pix_out_o(pix_out3), .edge_o(edg3),
    .cnt_clear_i(cnt_clear), .edge_count_o(ec3)
  );

  typedef struct {
    int gx_abs; int gy_abs; bit gx_neg; bit gy_neg;
    int mag; int pix; bit edg; int acc; bit lat;
  } exp_t;

  typedef struct {
    logic [31:0] gx_abs; logic [31:0] gy_abs; logic [31:0] mag; logic [31:0] pix;
    logic gx_neg; logic gy_neg; logic edg;
  } res_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0, n_popped = 0;
  int   cyc = 0, acc_cyc = 0;
  int   cnt20 = 0, cnt3 = 0;
  bit   lat_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [WW-1:0] w, input int m, input int t);
    exp_t e;
    int p[9];
    int gx, gy;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*PW +: PW]);
    gy = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    e.gx_abs = (gx < 0) ? -gx : gx;
    e.gy_abs = (gy < 0) ? -gy : gy;
    e.gx_neg = gx < 0;
    e.gy_neg = gy < 0;
    case (m)
      0:       e.mag = e.gx_abs + e.gy_abs;
      1:       e.mag = e.gy_abs;
      2:       e.mag = e.gx_abs;
      default: e.mag = (e.gx_abs > e.gy_abs) ? e.gx_abs : e.gy_abs;
    endcase
    e.pix = (e.mag > (1 << PW) - 1) ? (1 << PW) - 1 : e.mag;
    e.edg = e.mag >= t;
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  function automatic logic [WW-1:0] mkwin(input int p0, input int p1, input int p2,
                                          input int p3, input int p4, input int p5,
                                          input int p6, input int p7, input int p8);
    int p[9];
    logic [WW-1:0] w;
    p = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(p[k]);
    return w;
  endfunction

  function automatic logic [WW-1:0] stream_win(input int i);
    logic [WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'((i*37 + k*k*13 + i*k*29 + 5) % 256);
    return w;
  endfunction

  // Scoreboard: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit hs_edge;
    exp_t e;
    if (reset) begin
      q.delete();
      cnt20 = 0;
      cnt3  = 0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      chk("edge_count", ec20, cnt20);
      chk("edge_count_w3", ec3, cnt3);
      hs_edge = 0;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: out_valid=1 with mag %0d, expected no result", mag);
        end else begin
          chk("gx_abs", gx_abs, q[0].gx_abs);
          chk("gy_abs", gy_abs, q[0].gy_abs);
          chk("gx_neg", gx_neg, q[0].gx_neg);
          chk("gy_neg", gy_neg, q[0].gy_neg);
          chk("mag", mag, q[0].mag);
          chk("pix_out", pix_out, q[0].pix);
          chk("edge", edg, q[0].edg);
          if (out_ready) begin
            if (q[0].lat) chk("latency", cyc - q[0].acc, 3);
            hs_edge = q[0].edg;
            void'(q.pop_front());
            n_popped++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(window, int'(mode), int'(threshold));
        e.acc = cyc;
        e.lat = lat_chk;
        q.push_back(e);
      end
      if (cnt_clear) begin
        cnt20 = 0;
        cnt3  = 0;
      end else if (hs_edge) begin
        if (cnt20 < (1 << 20) - 1) cnt20++;
        if (cnt3 < 7) cnt3++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WW-1:0] w, input int m, input int t);
    int n;
    n = 0;
    in_valid  = 1'b1;
    window    = w;
    mode      = m[1:0];
    threshold = t[TW-1:0];
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output res_t r, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL result_timeout: out_valid got 0, expected 1");
    end
    r.gx_abs = 32'(gx_abs);
    r.gy_abs = 32'(gy_abs);
    r.mag    = 32'(mag);
    r.pix    = 32'(pix_out);
    r.gx_neg = gx_neg;
    r.gy_neg = gy_neg;
    r.edg    = edg;
    c = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int c, base, nv;
    logic [WW-1:0] w_top, w_bot, w_col;
    w_top = mkwin(255, 255, 255, 0, 0, 0, 0, 0, 0);
    w_bot = mkwin(0, 0, 0, 0, 0, 0, 255, 255, 255);
    w_col = mkwin(10, 0, 50, 10, 0, 50, 10, 0, 50);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    window = '0; mode = 2'd0; threshold = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mag", mag, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_gx_abs", gx_abs, 0);
    chk("rst_gy_abs", gy_abs, 0);
    chk("rst_flags", {gx_neg, gy_neg, edg}, 0);
    tick();

    // Flat window: zero gradient, exact latency.
    lat_chk = 1;
    send(mkwin(100, 100, 100, 100, 100, 100, 100, 100, 100), 0, 128);
    wait_result(r, c);
    chk("t1_latency", c - acc_cyc, 3);
    chk("t1_gx_abs", r.gx_abs, 0);
    chk("t1_gy_abs", r.gy_abs, 0);
    chk("t1_mag", r.mag, 0);
    chk("t1_pix", r.pix, 0);
    chk("t1_edge", r.edg, 0);
    tick();

    // Top-row step, then bottom-row step in gy-only mode.
    send(w_top, 0, 128);
    wait_result(r, c);
    chk("t2_gy_abs", r.gy_abs, 1020);
    chk("t2_gy_neg", r.gy_neg, 0);
    chk("t2_gx_abs", r.gx_abs, 0);
    chk("t2_mag", r.mag, 1020);
    chk("t2_pix", r.pix, 255);
    chk("t2_edge", r.edg, 1);
    tick();
    @(negedge clk);
    chk("t2_edge_count", ec20, 1);
    tick();
    send(w_bot, 1, 128);
    wait_result(r, c);
    chk("t2b_gy_abs", r.gy_abs, 1020);
    chk("t2b_gy_neg", r.gy_neg, 1);
    chk("t2b_mag", r.mag, 1020);
    tick();

    // Column gradient gx=+160 under modes 2, 3, 1.
    send(w_col, 2, 128);
    wait_result(r, c);
    chk("t3_gx_abs", r.gx_abs, 160);
    chk("t3_gx_neg", r.gx_neg, 0);
    chk("t3_m2_mag", r.mag, 160);
    chk("t3_m2_pix", r.pix, 160);
    chk("t3_m2_edge", r.edg, 1);
    tick();
    send(w_col, 3, 128);
    wait_result(r, c);
    chk("t3_m3_mag", r.mag, 160);
    tick();
    send(w_col, 1, 128);
    wait_result(r, c);
    chk("t3_m1_mag", r.mag, 0);
    chk("t3_m1_edge", r.edg, 0);
    tick();

    // Back-to-back stream with a 3-cycle downstream stall.
    lat_chk = 0;
    base = n_popped;
    fork
      begin
        for (int i = 0; i < 8; i++) send(stream_win(i), i % 4, 100 + 40 * i);
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_result_count", n_popped - base, 8);

    // Reset with two windows in flight.
    send(w_top, 0, 128);
    send(w_top, 0, 128);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_edge_count", ec20, 0);
    chk("t5_in_ready", in_ready, 1);
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("t5_ghosts", nv, 0);
    tick();

    // Saturation of the narrow counter, then clear against a live edge handshake.
    lat_chk = 1;
    for (int i = 0; i < 9; i++) send(w_top, 0, 128);
    drain();
    @(negedge clk);
    chk("t6_sat_w3", ec3, 7);
    chk("t6_count_w20", ec20, 9);
    tick();
    send(w_top, 0, 128);
    tick();
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    @(negedge clk);
    chk("t6_clear_w3", ec3, 0);
    chk("t6_clear_w20", ec20, 0);
    chk("t6_clear_drained", q.size(), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_gradient_pipe.md
Name: sobel_gradient_pipe

Overview:
Pipelined Sobel gradient engine that computes both horizontal (gx) and vertical (gy) gradients for one 3x3 window per cycle. It combines them into a selectable magnitude, saturates the result to an output pixel and flags edges against a programmable threshold. It sits between the line-buffer/window generator and the output frame writer, and replaces the combinational, vertical-only, 8-bit gradient path. It adds parametrised pixel width, valid/ready backpressure, mode selection and an edge counter.

Parameters:
PIX_W, 8, pixel width in bits (>=4)
CNT_W, 20, width of the edge counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  window valid
in_ready  out  1  block accepts window this cycle
window  in  9*PIX_W  pixels P0..P8, row-major, P0 top-left; Pk = window[k*PIX_W +: PIX_W]
mode  in  2  0=|gx|+|gy|, 1=|gy| only, 2=|gx| only, 3=max(|gx|,|gy|); sampled with window
threshold  in  PIX_W+3  edge threshold, compared against unsaturated magnitude
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
gx_abs  out  PIX_W+2  |gx|
gy_abs  out  PIX_W+2  |gy|
gx_neg  out  1  gx < 0
gy_neg  out  1  gy < 0
mag  out  PIX_W+3  combined magnitude per mode
pix_out  out  PIX_W  mag saturated to 2^PIX_W-1
edge  out  1  mag >= threshold
cnt_clear  in  1  clears edge_count
edge_count  out  CNT_W  number of accepted outputs with edge=1, saturating

Behaviour:
- Arithmetic (signed, width PIX_W+3; no overflow possible):
  - gy = (P0 + 2*P1 + P2) - (P6 + 2*P7 + P8), i.e. top row minus bottom row.
  - gx = (P2 + 2*P5 + P8) - (P0 + 2*P3 + P6), i.e. right column minus left column.
  - Range of each is ±4*(2^PIX_W-1).
- Absolute values: abs = two's-complement negate when the sign bit is set; result fits PIX_W+2 unsigned. neg flags = sign bits.
- Magnitude: mag per mode; width PIX_W+3 unsigned (mode 0 max = 8*(2^PIX_W-1)).
- pix_out = mag when mag <= 2^PIX_W-1, otherwise all ones.
- Pipeline: 3 stages, all registered, each carrying its own valid bit, with mode and threshold travelling alongside the data.
  - S1: row/column weighted sums and differences.
  - S2: abs and sign.
  - S3: mag, saturation, threshold compare; S3 registers drive the outputs.
- Latency: 3 cycles from accept (in_valid & in_ready) to out_valid, when out_ready is held high.
- Throughput: 1 window/cycle.
- Flow control: global advance = !out_valid | out_ready; in_ready = advance. All stages hold when advance=0. Bubbles propagate as valid=0.
- Output data stays stable while out_valid & !out_ready. No loss, duplication or reordering.
- Output data registers may hold stale values when out_valid=0; the bench checks them only when valid.
- edge_count: increments on out_valid & out_ready & edge; saturates at 2^CNT_W-1.
- cnt_clear: forces edge_count to 0 and wins over a simultaneous increment.
- Reset: all stage valids=0, out_valid=0, gx_abs=gy_abs=mag=pix_out=0, gx_neg=gy_neg=edge=0, edge_count=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-stream discards all in-flight windows.
- in_valid=0 with in_ready=1 inserts a bubble; there is no other state machine.

Decomposition:
- Package sobel_pkg holds:
  - mode enum (MODE_SUM, MODE_GY, MODE_GX, MODE_MAX);
  - width helper localparams GRAD_W=PIX_W+3, ABS_W=PIX_W+2;
  - a function returning the 3x3 pixel index for (row, col).
- One sub-module, sobel_kernel_sum: combinational weighted 1-2-1 difference of two 3-pixel vectors, instantiated twice in S1 (rows for gy, columns for gx).

Test Plan:
1. PIX_W=8, flat window all 100, mode 0, out_ready=1 -> out_valid exactly 3 cycles after accept; gx_abs=gy_abs=0, mag=0, pix_out=0, edge=0 at threshold 128.
2. Top row 255, rest 0, mode 0 -> gy_abs=1020, gy_neg=0, gx_abs=0, mag=1020, pix_out=255, edge=1, edge_count=1. Same window with bottom row 255 instead, mode 1 -> gy_abs=1020, gy_neg=1.
3. Left column 10, right column 50, middle column 0 -> gx=+160. Mode 2 gives mag=160; mode 3 gives 160; mode 1 gives 0, edge=0 at threshold 128.
4. Stream 8 distinct windows back-to-back; drop out_ready for 3 cycles mid-stream -> in_ready low exactly while out_valid & !out_ready; outputs held stable; all 8 results in order and correct.
5. Assert reset with 2 windows in flight -> next cycle out_valid=0, edge_count=0, in_ready=1; the 2 in-flight results never appear.
6. CNT_W=3: drive 9 edge results -> edge_count saturates at 7. Assert cnt_clear together with an edge handshake -> edge_count=0.
